// File: rtl/npu_job_sequencer_pkg.sv
// Shared types for the NPU job sequencer: array geometry, element/vector types and FSM states.
// Vector pack/unpack helpers convert between flat stream buses and per-element vectors.
package npu_pkg;

    localparam int ARR_DIM = 4;
    localparam int DATA_W  = 16;
    localparam int VEC_W   = ARR_DIM * DATA_W;

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t vec_t [ARR_DIM];
    typedef logic [VEC_W-1:0] vec_flat_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } seq_state_t;

    function automatic vec_t unpack_vec(input vec_flat_t flat);
        vec_t v;
        for (int i = 0; i < ARR_DIM; i++) begin
            v[i] = flat[i*DATA_W +: DATA_W];
        end
        return v;
    endfunction

    function automatic vec_flat_t pack_vec(input vec_t v);
        vec_flat_t flat;
        for (int i = 0; i < ARR_DIM; i++) begin
            flat[i*DATA_W +: DATA_W] = v[i];
        end
        return flat;
    endfunction

endpackage

// File: rtl/npu_job_sequencer_if.sv
// Valid/ready vector stream used for both the job input and the result output.
interface npu_stream_if import npu_pkg::*; #(
    parameter int W = VEC_W
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/npu_vec_buffer.sv
// N-deep vector store with per-lane addressing and write enables; reads are
// combinational and forward a same-cycle write so a freshly written lane is visible at once.
module npu_vec_buffer import npu_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we      [ARR_DIM],
    input  logic [AW-1:0] wr_addr [ARR_DIM],
    input  vec_t          wr_data,
    input  logic [AW-1:0] rd_addr [ARR_DIM],
    output vec_t          rd_data
);

    vec_t mem_r [DEPTH];

    // Storage update: each lane writes its own element at its own address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_r[d] <= '{default: '0};
            end
        end else begin
            for (int e = 0; e < ARR_DIM; e++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    if (we[e] && (wr_addr[e] == AW'(d))) begin
                        mem_r[d][e] <= wr_data[e];
                    end
                end
            end
        end
    end

    // Per-lane read mux with write-through forwarding.
    always_comb begin
        for (int e = 0; e < ARR_DIM; e++) begin
            elem_t sel_s;
            sel_s = '0;
            for (int d = 0; d < DEPTH; d++) begin
                sel_s = sel_s | (mem_r[d][e] & {DATA_W{rd_addr[e] == AW'(d)}});
            end
            if (we[e] && (wr_addr[e] == rd_addr[e])) begin
                rd_data[e] = wr_data[e];
            end else begin
                rd_data[e] = sel_s;
            end
        end
    end

endmodule

// File: rtl/npu_job_sequencer.sv
// Job controller for the systolic NPU: buffers a job, feeds it row-skewed into the array,
// deskews the column outputs into result vectors and streams them out under backpressure.
module npu_job_sequencer import npu_pkg::*; #(
    parameter int N_VEC   = 4,
    parameter int OUT_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    npu_stream_if.slave        in_stream,
    npu_stream_if.master       out_stream,
    output logic               npu_rst,
    output logic               npu_enable,
    output vec_t               npu_raw_in,
    input  vec_t               npu_raw_out
);

    localparam int T_RUN = N_VEC + OUT_LAT + ARR_DIM - 1;
    localparam int CW    = $clog2(T_RUN + 1);
    localparam int AW    = $clog2(N_VEC + 1);
    localparam logic [CW-1:0] T_LAST   = CW'(T_RUN - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(N_VEC - 1);

    seq_state_t    state_r;
    logic [CW-1:0] t_r;
    logic [AW-1:0] wr_idx_r, rd_idx_r;
    logic          busy_r, done_r, in_ready_r, out_valid_r, npu_rst_r, npu_enable_r;
    vec_t          raw_in_r, out_data_r;

    logic          in_fire_s, out_fire_s;
    vec_t          in_vec_s, skew_s, vec_rd_s, res_rd_s;
    logic          skew_ok_s   [ARR_DIM];
    logic          vec_we_s    [ARR_DIM];
    logic          res_we_s    [ARR_DIM];
    logic [AW-1:0] vec_waddr_s [ARR_DIM];
    logic [AW-1:0] vec_raddr_s [ARR_DIM];
    logic [AW-1:0] res_waddr_s [ARR_DIM];
    logic [AW-1:0] res_raddr_s [ARR_DIM];

    // A handshake coincident with abort is discarded.
    assign in_fire_s  = in_stream.valid & in_ready_r & ~abort;
    assign out_fire_s = out_valid_r & out_stream.ready & ~abort;
    assign in_vec_s   = unpack_vec(in_stream.data);

    // Skew/deskew addressing: row r reads vector (t_next - r); column c captures vector (t - OUT_LAT - c).
    always_comb begin
        int t_next;
        t_next = (state_r == RUN) ? (int'(t_r) + 1) : 0;
        for (int r = 0; r < ARR_DIM; r++) begin
            int src, cap;
            src = t_next - r;
            cap = int'(t_r) - OUT_LAT - r;
            vec_we_s[r]    = in_fire_s;
            vec_waddr_s[r] = wr_idx_r;
            res_we_s[r]    = (state_r == RUN) && (cap >= 0) && (cap < N_VEC);
            res_waddr_s[r] = AW'(cap);
            res_raddr_s[r] = (state_r == DRAIN) ? (rd_idx_r + AW'(1'b1)) : '0;
            if ((src >= 0) && (src < N_VEC)) begin
                skew_ok_s[r]   = 1'b1;
                vec_raddr_s[r] = AW'(src);
            end else begin
                skew_ok_s[r]   = 1'b0;
                vec_raddr_s[r] = '0;
            end
        end
    end

    // Rows outside the current vector window feed zeros into the array.
    always_comb begin
        for (int r = 0; r < ARR_DIM; r++) begin
            skew_s[r] = skew_ok_s[r] ? vec_rd_s[r] : '0;
        end
    end

    npu_vec_buffer #(.DEPTH(N_VEC), .AW(AW)) u_vec_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (vec_we_s),
        .wr_addr (vec_waddr_s),
        .wr_data (in_vec_s),
        .rd_addr (vec_raddr_s),
        .rd_data (vec_rd_s)
    );

    npu_vec_buffer #(.DEPTH(N_VEC), .AW(AW)) u_res_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (res_we_s),
        .wr_addr (res_waddr_s),
        .wr_data (npu_raw_out),
        .rd_addr (res_raddr_s),
        .rd_data (res_rd_s)
    );

    // Job FSM with registered control, skewed array input and result output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            t_r          <= '0;
            wr_idx_r     <= '0;
            rd_idx_r     <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            npu_rst_r    <= 1'b1;
            npu_enable_r <= 1'b0;
            raw_in_r     <= '{default: '0};
            out_data_r   <= '{default: '0};
        end else begin
            done_r <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                state_r      <= IDLE;
                t_r          <= '0;
                wr_idx_r     <= '0;
                rd_idx_r     <= '0;
                busy_r       <= 1'b0;
                in_ready_r   <= 1'b0;
                out_valid_r  <= 1'b0;
                npu_rst_r    <= 1'b1;
                npu_enable_r <= 1'b0;
                raw_in_r     <= '{default: '0};
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start && !abort) begin
                            state_r <= CLEAR;
                            busy_r  <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        state_r    <= LOAD;
                        in_ready_r <= 1'b1;
                        wr_idx_r   <= '0;
                    end
                    LOAD: begin
                        if (in_fire_s) begin
                            wr_idx_r <= wr_idx_r + AW'(1'b1);
                            if (wr_idx_r == IDX_LAST) begin
                                state_r      <= RUN;
                                in_ready_r   <= 1'b0;
                                npu_rst_r    <= 1'b0;
                                npu_enable_r <= 1'b1;
                                t_r          <= '0;
                                raw_in_r     <= skew_s;
                            end
                        end
                    end
                    RUN: begin
                        t_r <= t_r + CW'(1'b1);
                        if (t_r == T_LAST) begin
                            state_r      <= DRAIN;
                            npu_enable_r <= 1'b0;
                            out_valid_r  <= 1'b1;
                            rd_idx_r     <= '0;
                            raw_in_r     <= '{default: '0};
                            out_data_r   <= res_rd_s;
                        end else begin
                            raw_in_r <= skew_s;
                        end
                    end
                    DRAIN: begin
                        if (out_fire_s) begin
                            rd_idx_r <= rd_idx_r + AW'(1'b1);
                            if (rd_idx_r == IDX_LAST) begin
                                state_r     <= IDLE;
                                out_valid_r <= 1'b0;
                                busy_r      <= 1'b0;
                                done_r      <= 1'b1;
                                npu_rst_r   <= 1'b1;
                            end else begin
                                out_data_r <= res_rd_s;
                            end
                        end
                    end
                    default: begin
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                        in_ready_r   <= 1'b0;
                        out_valid_r  <= 1'b0;
                        npu_rst_r    <= 1'b1;
                        npu_enable_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign npu_rst          = npu_rst_r;
    assign npu_enable       = npu_enable_r;
    assign npu_raw_in       = raw_in_r;
    assign in_stream.ready  = in_ready_r;
    assign out_stream.valid = out_valid_r;
    assign out_stream.data  = pack_vec(out_data_r);

endmodule

// File: tb/tb_npu_job_sequencer.sv
// Self-checking bench for npu_job_sequencer: table-driven skew/deskew checks plus
// directed sequences for backpressure, abort, input gaps and start/abort collisions.
module tb_npu_job_sequencer;
    import npu_pkg::*;

    typedef struct {
        int t;
        int e0, e1, e2, e3;
    } row_vec_t;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic busy, done, npu_rst, npu_enable;
    vec_t npu_raw_in, npu_raw_out;

    npu_stream_if #(.W(VEC_W)) in_stream ();
    npu_stream_if #(.W(VEC_W)) out_stream ();

    npu_job_sequencer #(.N_VEC(4), .OUT_LAT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .in_stream   (in_stream),
        .out_stream  (out_stream),
        .npu_rst     (npu_rst),
        .npu_enable  (npu_enable),
        .npu_raw_in  (npu_raw_in),
        .npu_raw_out (npu_raw_out)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       tb_t = 0;
    int       run_len = 0;
    int       done_cnt = 0;
    vec_t     raw_log [32];
    row_vec_t skew_tbl [8];
    row_vec_t res_tbl [4];

    // NPU stand-in: column c outputs t*10+c during RUN; also logs what the DUT feeds each cycle.
    always @(negedge clk) begin
        if (npu_enable) begin
            for (int c = 0; c < ARR_DIM; c++) npu_raw_out[c] = DATA_W'(tb_t * 10 + c);
            if (tb_t < 32) raw_log[tb_t] = npu_raw_in;
            tb_t = tb_t + 1;
        end else begin
            if (tb_t != 0) run_len = tb_t;
            tb_t = 0;
            for (int c = 0; c < ARR_DIM; c++) npu_raw_out[c] = '0;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input int v);
        int n = 0;
        in_stream.valid = 1'b1;
        for (int r = 0; r < ARR_DIM; r++) in_stream.data[r*DATA_W +: DATA_W] = DATA_W'(4 * v + r + 1);
        while (!in_stream.ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("in_ready_timeout", 64'd0, 64'd1);
        tick();
        in_stream.valid = 1'b0;
    endtask

    task automatic load_job(input int gap, input logic start_mid);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int v = 0; v < 4; v++) begin
            send_vec(v);
            if (v < 3) begin
                for (int g = 0; g < gap; g++) begin
                    start = start_mid && (g == 0);
                    chk("gap_in_ready", 64'(in_stream.ready), 64'd1);
                    chk("gap_enable", 64'(npu_enable), 64'd0);
                    tick();
                    start = 1'b0;
                end
            end
        end
        chk("run_start_enable", 64'(npu_enable), 64'd1);
        chk("run_start_npu_rst", 64'(npu_rst), 64'd0);
        chk("run_start_in_ready", 64'(in_stream.ready), 64'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_stream.valid && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_skew();
        for (int i = 0; i < 8; i++) begin
            chk("skew_r0", 64'(raw_log[skew_tbl[i].t][0]), 64'(skew_tbl[i].e0));
            chk("skew_r1", 64'(raw_log[skew_tbl[i].t][1]), 64'(skew_tbl[i].e1));
            chk("skew_r2", 64'(raw_log[skew_tbl[i].t][2]), 64'(skew_tbl[i].e2));
            chk("skew_r3", 64'(raw_log[skew_tbl[i].t][3]), 64'(skew_tbl[i].e3));
        end
    endtask

    task automatic drain(input logic [7:0] pat);
        int k = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [VEC_W-1:0] held = '0;
        while (k < 4 && cyc < 100) begin
            out_stream.ready = pat[cyc % 8];
            if (out_stream.valid) begin
                if (stalled) chk("stall_hold", out_stream.data, held);
                if (out_stream.ready) begin
                    chk("res_c0", 64'(out_stream.data[0*DATA_W +: DATA_W]), 64'(res_tbl[k].e0));
                    chk("res_c1", 64'(out_stream.data[1*DATA_W +: DATA_W]), 64'(res_tbl[k].e1));
                    chk("res_c2", 64'(out_stream.data[2*DATA_W +: DATA_W]), 64'(res_tbl[k].e2));
                    chk("res_c3", 64'(out_stream.data[3*DATA_W +: DATA_W]), 64'(res_tbl[k].e3));
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_stream.data;
                end
            end else begin
                chk("drain_valid_drop", 64'd0, 64'd1);
            end
            tick();
            cyc++;
        end
        out_stream.ready = 1'b0;
        chk("drain_count", 64'(k), 64'd4);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("out_valid_after_done", 64'(out_stream.valid), 64'd0);
    endtask

    initial begin
        skew_tbl[0] = '{0, 1, 0, 0, 0};
        skew_tbl[1] = '{1, 5, 2, 0, 0};
        skew_tbl[2] = '{2, 9, 6, 3, 0};
        skew_tbl[3] = '{3, 13, 10, 7, 4};
        skew_tbl[4] = '{4, 0, 14, 11, 8};
        skew_tbl[5] = '{5, 0, 0, 15, 12};
        skew_tbl[6] = '{6, 0, 0, 0, 16};
        skew_tbl[7] = '{8, 0, 0, 0, 0};
        res_tbl[0]  = '{0, 40, 51, 62, 73};
        res_tbl[1]  = '{1, 50, 61, 72, 83};
        res_tbl[2]  = '{2, 60, 71, 82, 93};
        res_tbl[3]  = '{3, 70, 81, 92, 103};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        in_stream.valid = 1'b0;
        in_stream.data = '0;
        out_stream.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_npu_rst", 64'(npu_rst), 64'd1);
        chk("rst_out_valid", 64'(out_stream.valid), 64'd0);
        chk("rst_in_ready", 64'(in_stream.ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        for (int r = 0; r < ARR_DIM; r++) chk("rst_raw_in", 64'(npu_raw_in[r]), 64'd0);
        rst = 1'b0;
        tick();

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle_busy", 64'(busy), 64'd0);
        chk("start_abort_idle_npu_rst", 64'(npu_rst), 64'd1);
        tick();

        load_job(0, 1'b0);
        wait_valid();
        check_skew();
        drain(8'b1001_1001);
        repeat (3) tick();
        chk("done_count_job1", 64'(done_cnt), 64'd1);
        chk("run_length", 64'(run_len), 64'd11);

        load_job(0, 1'b0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_npu_rst", 64'(npu_rst), 64'd1);
        chk("abort_enable", 64'(npu_enable), 64'd0);
        chk("abort_out_valid", 64'(out_stream.valid), 64'd0);
        chk("abort_in_ready", 64'(in_stream.ready), 64'd0);
        repeat (20) tick();
        chk("abort_no_done", 64'(done_cnt), 64'd1);
        chk("abort_run_length", 64'(run_len), 64'd3);

        load_job(3, 1'b1);
        wait_valid();
        check_skew();
        drain(8'hFF);
        repeat (3) tick();
        chk("done_count_job3", 64'(done_cnt), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "watchdog");
    end

endmodule
